sreceiver: RTL and testbench

// Serial-to-parallel receiver: the far end of a serial link driven by a universal

---
 rtl/sreceiver.sv | 85 ++++++++
 tb/tb_sreceiver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sreceiver.sv
// Serial-to-parallel receiver: assembles W serial bits into a word, holds it
// behind a valid/ack handshake and flags overruns with a sticky ovf bit.
module sreceiver #(
  parameter int unsigned W         = 8,
  parameter int unsigned CW        = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          sin,
  input  logic          ack,
  output logic [W-1:0]  q,
  output logic          valid,
  output logic          busy,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  logic [W-1:0]  sh_q, sh_d, sh_shift;
  logic [W-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          last_bit;

  always_comb begin
    if (LSB_FIRST) sh_shift = {sin, sh_q[W-1:1]};
    else           sh_shift = {sh_q[W-2:0], sin};
  end

  assign last_bit = (cnt_q == CW'(W - 1));

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    // ack is honoured on any edge; a completing word below may re-assert valid
    if (valid_q && ack) valid_d = 1'b0;
    if (clr) begin
      sh_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
      sh_d = sh_shift;
      if (last_bit) begin
        cnt_d = '0;
        if (!valid_q || ack) begin
          q_d     = sh_shift;
          valid_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
  assign cnt   = cnt_q;
  assign ovf   = ovf_q;
  assign busy  = (cnt_q != '0);

endmodule

// File: tb/tb_sreceiver.sv
// Directed bench for sreceiver: LSB-first instance for framing, handshake,
// overrun and restart cases; MSB-first instance for bit ordering.
module tb_sreceiver;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_a = 1'b0, en_a = 1'b0, sin_a = 1'b0, ack_a = 1'b0;
  logic       clr_b = 1'b0, en_b = 1'b0, sin_b = 1'b0, ack_b = 1'b0;
  logic [7:0] q_a, q_b;
  logic       valid_a, valid_b, busy_a, busy_b, ovf_a, ovf_b;
  logic [3:0] cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ck = ~ck;

  sreceiver #(.W(8), .CW(4), .LSB_FIRST(1'b1)) u_dut_a (
    .ck(ck), .rst_n(rst_n), .clr(clr_a), .en(en_a), .sin(sin_a), .ack(ack_a),
    .q(q_a), .valid(valid_a), .busy(busy_a), .cnt(cnt_a), .ovf(ovf_a)
  );

  sreceiver #(.W(8), .CW(4), .LSB_FIRST(1'b0)) u_dut_b (
    .ck(ck), .rst_n(rst_n), .clr(clr_b), .en(en_b), .sin(sin_b), .ack(ack_b),
    .q(q_b), .valid(valid_b), .busy(busy_b), .cnt(cnt_b), .ovf(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic send_a(input logic b, input logic with_ack);
    en_a = 1'b1; sin_a = b; ack_a = with_ack;
    tick();
    en_a = 1'b0; ack_a = 1'b0;
  endtask

  task automatic word_a(input logic [7:0] w, input logic ack_last);
    for (int i = 0; i < 8; i++) send_a(w[i], (i == 7) ? ack_last : 1'b0);
  endtask

  task automatic ack_pulse_a();
    ack_a = 1'b1;
    tick();
    ack_a = 1'b0;
  endtask

  task automatic clr_pulse_a();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
  endtask

  initial begin
    logic [7:0] bits1;
    logic [7:0] bits6;
    bits1 = 8'b0011_0101;  // sent LSB first: 1,0,1,0,1,1,0,0
    bits6 = 8'b0101_0001;  // sent MSB first: 0,1,0,1,0,0,0,1

    #2;
    check("rst_q", q_a, 8'h00);
    check("rst_valid", valid_a, 1'b0);
    check("rst_cnt", cnt_a, 4'd0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_ovf", ovf_a, 1'b0);
    #10 rst_n = 1'b1;
    tick();

    // 1: back-to-back frame
    for (int i = 0; i < 8; i++) begin
      send_a(bits1[i], 1'b0);
      if (i < 7) begin
        check("t1_busy", busy_a, 1'b1);
        check("t1_cnt", cnt_a, 32'(i + 1));
        check("t1_valid_lo", valid_a, 1'b0);
      end
    end
    check("t1_q", q_a, 8'h35);
    check("t1_valid", valid_a, 1'b1);
    check("t1_busy_end", busy_a, 1'b0);
    check("t1_cnt_end", cnt_a, 4'd0);

    // 2: same word with a 3-cycle gap after bit 4
    ack_pulse_a();
    check("t2_ack_valid", valid_a, 1'b0);
    check("t2_ack_q", q_a, 8'h35);
    for (int i = 0; i < 8; i++) begin
      send_a(bits1[i], 1'b0);
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          check("t2_gap_cnt", cnt_a, 4'd4);
        end
      end
    end
    check("t2_q", q_a, 8'h35);
    check("t2_valid", valid_a, 1'b1);

    // 3: overrun while unacked, then clr and ack
    word_a(8'hA0, 1'b0);
    check("t3_q_kept", q_a, 8'h35);
    check("t3_ovf", ovf_a, 1'b1);
    check("t3_valid", valid_a, 1'b1);
    clr_pulse_a();
    check("t3_clr_ovf", ovf_a, 1'b0);
    check("t3_clr_valid", valid_a, 1'b1);
    ack_pulse_a();
    check("t3_ack_valid", valid_a, 1'b0);

    // 4: ack on the completing edge replaces the held word
    word_a(8'h35, 1'b0);
    check("t4_pre_valid", valid_a, 1'b1);
    word_a(8'h51, 1'b1);
    check("t4_q", q_a, 8'h51);
    check("t4_valid", valid_a, 1'b1);
    check("t4_ovf", ovf_a, 1'b0);

    // 5a: clr mid-frame, then a full frame
    ack_pulse_a();
    for (int i = 0; i < 5; i++) send_a(1'b1, 1'b0);
    check("t5_cnt5", cnt_a, 4'd5);
    clr_pulse_a();
    check("t5_clr_cnt", cnt_a, 4'd0);
    check("t5_clr_busy", busy_a, 1'b0);
    word_a(8'hC3, 1'b0);
    check("t5_clr_q", q_a, 8'hC3);
    check("t5_clr_valid", valid_a, 1'b1);

    // 5b: asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send_a(1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_cnt", cnt_a, 4'd0);
    check("t5_rst_busy", busy_a, 1'b0);
    check("t5_rst_valid", valid_a, 1'b0);
    check("t5_rst_q", q_a, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_a(((8'hC3 >> i) & 8'h01) != 0, 1'b0);
    check("t5_rst_valid_lo", valid_a, 1'b0);
    send_a(1'b1, 1'b0);
    check("t5_rst_q_c3", q_a, 8'hC3);
    check("t5_rst_valid_hi", valid_a, 1'b1);

    // 6: MSB-first instance
    for (int i = 7; i >= 0; i--) begin
      en_b = 1'b1; sin_b = bits6[i];
      tick();
    end
    en_b = 1'b0;
    check("t6_q", q_b, 8'h51);
    check("t6_valid", valid_b, 1'b1);
    check("t6_ovf", ovf_b, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
